// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and address range helper for reg_file_param
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 8;

  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/wr_decoder_param.sv
// rtl/wr_decoder_param.sv - one-hot write decoder producing per-register load enables
// Enables are gated by the pending-valid bit and the range check; register 0 never loads when hard-wired.
module wr_decoder_param
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int ZERO_REG = 0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             valid,
  input  logic [AW-1:0]    addr,
  output logic [DEPTH-1:0] en
);

  logic ok;
  assign ok = addr_in_range(32'(addr), 32'(DEPTH));

  always_comb begin
    en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      en[i] = valid && ok && (addr == AW'(i));
    end
    if (ZERO_REG != 0) begin
      en[0] = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file, pipelined write port, two bypassed read ports
// Writes land in a one-entry pending stage, commit one edge later; reads may forward the pending entry.
module reg_file_param
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int ZERO_REG = 0,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    wAddr,
  input  logic [WIDTH-1:0] wData,
  input  logic [AW-1:0]    rAddr0,
  output logic [WIDTH-1:0] rData0,
  input  logic [AW-1:0]    rAddr1,
  output logic [WIDTH-1:0] rData1,
  output logic             wr_ack,
  output logic             addr_err,
  input  logic             clr_err
);

  logic             pend_valid;
  logic [AW-1:0]    pend_addr;
  logic [WIDTH-1:0] pend_data;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] load_en;
  logic             w_ok, r0_ok, r1_ok, err_event;

  assign w_ok      = addr_in_range(32'(wAddr), 32'(DEPTH));
  assign r0_ok     = addr_in_range(32'(rAddr0), 32'(DEPTH));
  assign r1_ok     = addr_in_range(32'(rAddr1), 32'(DEPTH));
  assign err_event = (we && !w_ok) || !r0_ok || !r1_ok;

  wr_decoder_param #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_dec (
    .valid (pend_valid),
    .addr  (pend_addr),
    .en    (load_en)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      wr_ack     <= 1'b0;
      addr_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      pend_valid <= we && w_ok;
      if (we && w_ok) begin
        pend_addr <= wAddr;
        pend_data <= wData;
      end
      wr_ack <= pend_valid;
      for (int i = 0; i < DEPTH; i++) begin
        if (load_en[i]) begin
          regs[i] <= pend_data;
        end
      end
      // A new error in the same cycle as clr_err keeps the flag set.
      if (err_event) begin
        addr_err <= 1'b1;
      end else if (clr_err) begin
        addr_err <= 1'b0;
      end
    end
  end

  always_comb begin
    rData0 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rAddr0 == AW'(i)) rData0 = regs[i];
    end
    if (BYPASS != 0 && pend_valid && pend_addr == rAddr0) rData0 = pend_data;
    if (!r0_ok || (ZERO_REG != 0 && rAddr0 == '0)) rData0 = '0;
  end

  always_comb begin
    rData1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rAddr1 == AW'(i)) rData1 = regs[i];
    end
    if (BYPASS != 0 && pend_valid && pend_addr == rAddr1) rData1 = pend_data;
    if (!r1_ok || (ZERO_REG != 0 && rAddr1 == '0)) rData1 = '0;
  end

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - self-checking bench for reg_file_param across four configurations
module tb_reg_file_param;

  localparam int NK = 4;
  localparam int MAXC = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, we, clr_err;
  logic [2:0] wAddr, rAddr0, rAddr1;
  logic [31:0] wData;
  logic [NK-1:0][31:0] rd0, rd1;
  logic [NK-1:0] ack, err;

  int cfg_depth [NK] = '{8, 8, 8, 6};
  int cfg_zero  [NK] = '{0, 0, 1, 0};
  int cfg_byp   [NK] = '{1, 0, 1, 1};

  reg_file_param #(.WIDTH(32), .DEPTH(8), .ZERO_REG(0), .BYPASS(1)) u_base (
    .clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr), .wData(wData),
    .rAddr0(rAddr0), .rData0(rd0[0]), .rAddr1(rAddr1), .rData1(rd1[0]),
    .wr_ack(ack[0]), .addr_err(err[0]), .clr_err(clr_err));
  reg_file_param #(.WIDTH(32), .DEPTH(8), .ZERO_REG(0), .BYPASS(0)) u_nobyp (
    .clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr), .wData(wData),
    .rAddr0(rAddr0), .rData0(rd0[1]), .rAddr1(rAddr1), .rData1(rd1[1]),
    .wr_ack(ack[1]), .addr_err(err[1]), .clr_err(clr_err));
  reg_file_param #(.WIDTH(32), .DEPTH(8), .ZERO_REG(1), .BYPASS(1)) u_zero (
    .clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr), .wData(wData),
    .rAddr0(rAddr0), .rData0(rd0[2]), .rAddr1(rAddr1), .rData1(rd1[2]),
    .wr_ack(ack[2]), .addr_err(err[2]), .clr_err(clr_err));
  reg_file_param #(.WIDTH(32), .DEPTH(6), .ZERO_REG(0), .BYPASS(1)) u_d6 (
    .clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr), .wData(wData),
    .rAddr0(rAddr0), .rData0(rd0[3]), .rAddr1(rAddr1), .rData1(rd1[3]),
    .wr_ack(ack[3]), .addr_err(err[3]), .clr_err(clr_err));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  bit          lg_rst [MAXC];
  bit          lg_we  [MAXC];
  logic [2:0]  lg_wa  [MAXC];
  logic [31:0] lg_wd  [MAXC];
  bit          model_err [NK];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cycle %0d: got %h want %h", name, k, cyc, act, exp);
    end
  endtask

  // Latest surviving write to the address, visible after 1 cycle with bypass or 2 without.
  function automatic logic [31:0] exp_read(input int k, input int t, input logic [2:0] a);
    int lag;
    lag = (cfg_byp[k] != 0) ? 1 : 2;
    if (int'(a) >= cfg_depth[k]) return 32'h0;
    if (cfg_zero[k] != 0 && a == 3'd0) return 32'h0;
    for (int c = t - 1; c >= 1; c--) begin
      if (lg_rst[c]) return 32'h0;
      if (c <= t - lag && lg_we[c] && lg_wa[c] == a) return lg_wd[c];
    end
    return 32'h0;
  endfunction

  function automatic logic exp_ack(input int k, input int t);
    return lg_we[t-2] && (int'(lg_wa[t-2]) < cfg_depth[k]) && !lg_rst[t-2] && !lg_rst[t-1];
  endfunction

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      lg_rst[cyc] = !reset_n;
      lg_we[cyc]  = we;
      lg_wa[cyc]  = wAddr;
      lg_wd[cyc]  = wData;
      for (int k = 0; k < NK; k++) begin
        if (cyc >= 2) begin
          check("rdata0", k, rd0[k], exp_read(k, cyc, rAddr0));
          check("rdata1", k, rd1[k], exp_read(k, cyc, rAddr1));
          check("wr_ack", k, 32'(ack[k]), 32'(exp_ack(k, cyc)));
          check("addr_err", k, 32'(err[k]), 32'(model_err[k]));
        end
        if (!reset_n) model_err[k] = 1'b0;
        else if ((we && int'(wAddr) >= cfg_depth[k]) || int'(rAddr0) >= cfg_depth[k] ||
                 int'(rAddr1) >= cfg_depth[k]) model_err[k] = 1'b1;
        else if (clr_err) model_err[k] = 1'b0;
      end
    end
  end

  task automatic drv(input logic w, input logic [2:0] wa, input logic [31:0] wd,
                     input logic [2:0] r0, input logic [2:0] r1, input logic clr, input logic rn);
    @(posedge clk);
    #1;
    we = w; wAddr = wa; wData = wd; rAddr0 = r0; rAddr1 = r1; clr_err = clr; reset_n = rn;
    @(negedge clk);
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [2:0]  r0;
    logic [2:0]  r1;
  } vec_t;

  vec_t tbl [10] = '{
    '{1'b1, 3'd1, 32'h0000_0101, 3'd1, 3'd1},
    '{1'b1, 3'd2, 32'h0000_0202, 3'd1, 3'd2},
    '{1'b1, 3'd1, 32'h0000_0111, 3'd2, 3'd1},
    '{1'b0, 3'd0, 32'h0,         3'd1, 3'd2},
    '{1'b1, 3'd4, 32'h4444_0004, 3'd4, 3'd3},
    '{1'b1, 3'd0, 32'hCAFE_F00D, 3'd0, 3'd4},
    '{1'b0, 3'd0, 32'h0,         3'd0, 3'd5},
    '{1'b1, 3'd5, 32'h5555_AAAA, 3'd5, 3'd0},
    '{1'b0, 3'd0, 32'h0,         3'd5, 3'd1},
    '{1'b0, 3'd0, 32'h0,         3'd2, 3'd0}
  };

  initial begin
    reset_n = 1'b0; we = 1'b0; clr_err = 1'b0;
    wAddr = 3'd0; wData = 32'h0; rAddr0 = 3'd0; rAddr1 = 3'd0;
    for (int k = 0; k < NK; k++) model_err[k] = 1'b0;

    drv(0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 1);
    check("reset_ack", 0, 32'(ack[0]), 32'h0);
    check("reset_err", 0, 32'(err[0]), 32'h0);

    // Fill every register, then reset and confirm everything reads zero.
    for (int i = 0; i < 8; i++) drv(1, 3'(i), 32'hA5A5_0000 + 32'(i), 0, 0, 0, 1);
    drv(0, 0, 0, 6, 1, 0, 1);
    drv(0, 0, 0, 6, 1, 0, 1);
    check("pre_rst_rd", 0, rd0[0], 32'hA5A5_0006);
    check("pre_rst_rd", 1, rd1[1], 32'hA5A5_0001);
    check("pre_rst_zero", 2, rd0[2], 32'hA5A5_0006);
    check("pre_rst_err", 3, 32'(err[3]), 32'h1);
    drv(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 0, 3'(i), 3'(i + 4), 0, 1);
      check("post_rst_rd0", 0, rd0[0], 32'h0);
      check("post_rst_rd1", 0, rd1[0], 32'h0);
      if (i == 0) check("post_rst_err", 3, 32'(err[3]), 32'h0);
    end
    drv(0, 0, 0, 0, 0, 1, 1);

    // Basic write: bypass visible next cycle, commit one cycle later.
    drv(1, 3, 32'h1234_5678, 3, 0, 0, 1);
    check("same_cycle_rd", 0, rd0[0], 32'h0);
    drv(0, 0, 0, 3, 0, 0, 1);
    check("bypass_rd", 0, rd0[0], 32'h1234_5678);
    check("nobyp_rd_early", 1, rd0[1], 32'h0);
    check("ack_early", 0, 32'(ack[0]), 32'h0);
    drv(0, 0, 0, 3, 0, 0, 1);
    check("ack_commit", 0, 32'(ack[0]), 32'h1);
    check("nobyp_rd", 1, rd0[1], 32'h1234_5678);

    // Back-to-back writes to the same address.
    drv(1, 5, 32'h11, 5, 0, 0, 1);
    drv(1, 5, 32'h22, 5, 0, 0, 1);
    check("b2b_first", 0, rd0[0], 32'h11);
    drv(0, 0, 0, 5, 0, 0, 1);
    check("b2b_last", 0, rd0[0], 32'h22);
    check("b2b_ack1", 0, 32'(ack[0]), 32'h1);
    drv(0, 0, 0, 5, 0, 0, 1);
    check("b2b_ack2", 0, 32'(ack[0]), 32'h1);
    check("b2b_nobyp", 1, rd0[1], 32'h22);

    // Hard-wired zero register.
    drv(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 0, 1);
      check("zero_rd0", 2, rd0[2], 32'h0);
      check("zero_rd1", 2, rd1[2], 32'h0);
      if (i == 1) check("zero_ack", 2, 32'(ack[2]), 32'h1);
    end

    // Out-of-range write and error flag handling on the DEPTH=6 instance.
    drv(1, 7, 32'hDEAD_0007, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 1);
    check("oor_err", 3, 32'(err[3]), 32'h1);
    check("inrange_err", 0, 32'(err[0]), 32'h0);
    drv(0, 0, 0, 0, 0, 1, 1);
    check("oor_noack", 3, 32'(ack[3]), 32'h0);
    check("inrange_ack", 0, 32'(ack[0]), 32'h1);
    drv(0, 0, 0, 0, 0, 0, 1);
    check("clr_err", 3, 32'(err[3]), 32'h0);
    drv(0, 0, 0, 6, 0, 0, 1);
    check("oor_rd", 3, rd0[3], 32'h0);
    drv(0, 0, 0, 0, 6, 1, 1);
    drv(0, 0, 0, 0, 0, 0, 1);
    check("set_wins", 3, 32'(err[3]), 32'h1);
    drv(0, 0, 0, 0, 0, 1, 1);
    drv(0, 0, 0, 0, 0, 0, 1);
    check("clr_again", 3, 32'(err[3]), 32'h0);

    // Reset arriving one edge after a write discards it.
    drv(1, 2, 32'h0000_BEEF, 2, 0, 0, 1);
    drv(0, 0, 0, 2, 0, 0, 0);
    check("rst_mid_byp", 0, rd0[0], 32'h0000_BEEF);
    drv(0, 0, 0, 2, 0, 0, 1);
    check("rst_mid_rd", 0, rd0[0], 32'h0);
    check("rst_mid_ack", 0, 32'(ack[0]), 32'h0);
    drv(0, 0, 0, 2, 0, 0, 1);
    check("rst_mid_ack2", 0, 32'(ack[0]), 32'h0);

    // Mixed directed sweep, checked against the model only.
    foreach (tbl[i]) drv(tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].r0, tbl[i].r1, 0, 1);
    drv(0, 0, 0, 1, 4, 0, 1);
    drv(0, 0, 0, 0, 5, 0, 1);
    check("sweep_rd", 0, rd1[0], 32'h5555_AAAA);
    check("sweep_zero", 2, rd0[2], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised register file, the successor to the fixed 8-entry write-decode path.
- Provides DEPTH registers of WIDTH bits, one pipelined write port and two combinational read ports.
- Adds read-after-write bypass, an optional hard-wired zero register, and an out-of-range address error flag.
- Sits between the datapath write-back stage and operand fetch.

Parameters:
- WIDTH, 32, data width of each register in bits.
- DEPTH, 8, number of registers; must be at least 2; need not be a power of two.
- ZERO_REG, 0, when 1, register 0 always reads 0 and writes to it have no effect.
- BYPASS, 1, when 1, read ports forward a pending, uncommitted write.
- AW (localparam), clog2(DEPTH), address width.

Ports:
- clk  in  1  Single clock; all state updates on its rising edge.
- reset_n  in  1  Reset: one clock; reset is synchronous and active-low.
- we  in  1  Write request, sampled on the rising edge.
- wAddr  in  AW  Write address.
- wData  in  WIDTH  Write data.
- rAddr0  in  AW  Read port 0 address.
- rData0  out  WIDTH  Read port 0 data, combinational.
- rAddr1  in  AW  Read port 1 address.
- rData1  out  WIDTH  Read port 1 data, combinational.
- wr_ack  out  1  One-cycle pulse when a write commits to the array.
- addr_err  out  1  Sticky flag: a write or read used an address >= DEPTH.
- clr_err  in  1  Clears addr_err.

Behaviour:
- Reset (reset_n=0 at a rising edge): all registers become 0; pend_valid, wr_ack and addr_err become 0. Any pending write is discarded, including one arriving in the same cycle.
- Write pipeline, stage 1: at edge E with we=1 and wAddr<DEPTH, the pending stage loads pend_valid=1, pend_addr=wAddr, pend_data=wData. With we=0, pend_valid becomes 0.
- Write pipeline, stage 2: at edge E+1, if pend_valid, array[pend_addr] <= pend_data and wr_ack=1 for that cycle; otherwise wr_ack=0.
- Write latency: 2 edges to array contents, 1 edge to bypassed read visibility.
- Back-to-back writes: accepted every cycle with no stall. Consecutive writes to the same address commit in order, so the last one wins.
- Read: rDataN = array[rAddrN], combinational.
  - If BYPASS=1, pend_valid=1 and pend_addr==rAddrN, rDataN = pend_data instead.
  - If BYPASS=0, new data is visible only after commit.
- Zero register (ZERO_REG=1):
  - A write to address 0 still enters the pipeline and still produces wr_ack, but the array is not modified.
  - Reads of address 0 return 0 and are never bypassed.
- Out of range:
  - A write with we=1 and wAddr>=DEPTH is dropped (no pending entry, no wr_ack) and sets addr_err at the next edge.
  - A read with rAddrN>=DEPTH returns 0 and sets addr_err at the next edge.
  - When DEPTH is a power of two, this condition never occurs.
- Error flag priority: if clr_err and a new error coincide, set wins. addr_err holds until clr_err or reset.
- Simultaneous read and write to the same address in the same cycle: the read returns the old value; the new value is seen from the next cycle via bypass.
- No X propagation: all outputs are defined from the first post-reset cycle.

Decomposition:
- Shared package (regfile_pkg):
  - Default WIDTH and DEPTH constants.
  - An addr_in_range function with DEPTH as its argument.
- One sub-module, wr_decoder_param:
  - Parametrised AW-to-DEPTH one-hot decoder gated by the pending valid and range check.
  - Produces per-register load enables.
  - Generalises the existing 3-to-8 decode-and-gate structure.
- Read muxes and bypass compare stay inline in the top module.

Test Plan:
- Reset: load all 8 registers with 0xA5A5_0000+i, assert reset_n=0 for one edge → all reads return 0, wr_ack=0, addr_err=0.
- Basic write:
  - Cycle 0: we=1, wAddr=3, wData=0x1234_5678.
  - Cycle 1: rAddr0=3 returns 0x1234_5678 (bypass).
  - Cycle 2: wr_ack=1; with BYPASS=0, the same value is first visible here.
- Back-to-back same address: write 5←0x11 then 5←0x22 on consecutive cycles → two wr_ack pulses, final read of 5 returns 0x22, no intermediate stale 0x11 after cycle 2.
- ZERO_REG=1: write 0←0xFFFF_FFFF → wr_ack=1, rData0 and rData1 at address 0 return 0 on every cycle.
- DEPTH=6: write to address 7 → no wr_ack, addr_err=1 next cycle.
  - Clear: clr_err for one cycle → addr_err=0.
  - Coincident: clr_err together with a read of address 6 → addr_err stays 1.
- Reset mid-write: we=1, wAddr=2, wData=0xBEEF, then reset_n=0 on the next edge → register 2 reads 0 and no wr_ack is seen.
